// File: rtl/router_pkg.sv
// Shared router definitions: drain FSM states, header field positions,
// channel count and the mod-3 channel increment.
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_ABORT
    } state_t;

    localparam int LEN_MSB = 5;
    localparam int LEN_LSB = 2;
    localparam int CH_MSB  = 1;
    localparam int CH_LSB  = 0;
    localparam int NUM_CH  = 3;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch >= 2'(NUM_CH - 1)) ? 2'd0 : ch + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin pick: first set req bit at ptr, ptr+1, ptr+2.
// Ports: req[2:0], ptr[1:0] in; gnt[1:0] (valid only when any), any out.
module rr_pick3
    import router_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt,
    output logic       any
);

    always_comb begin
        any = |req;
        gnt = 2'd0;
        case (ptr)
            2'd1:    gnt = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    gnt = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: gnt = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

endmodule

// File: rtl/router_drain_arbiter.sv
// Egress scheduler: grants one of three FWFT FIFOs per packet round-robin,
// frames the byte stream with sop/eop and aborts packets stalled on underrun.
// Ports: clk, rst; fifo_vld/fifo_data_0..2, chan_en, out_ready in;
//        read_enb, out_data/valid/sop/eop/ch, busy, timeout_err, hdr_err out.
module router_drain_arbiter
    import router_pkg::*;
#(
    parameter  int DW      = 8,
    parameter  int TIMEOUT = 16,
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    fifo_vld,
    input  logic [DW-1:0] fifo_data_0,
    input  logic [DW-1:0] fifo_data_1,
    input  logic [DW-1:0] fifo_data_2,
    input  logic [2:0]    chan_en,
    input  logic          out_ready,
    output logic [2:0]    read_enb,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    output logic [1:0]    out_ch,
    output logic          busy,
    output logic          timeout_err,
    output logic          hdr_err
);

    state_t        state;
    logic [1:0]    grant;
    logic [1:0]    rr_ptr;
    logic [4:0]    rem;
    logic [TW-1:0] stall;

    logic [1:0]    pick;
    logic          pick_any;
    logic          vld_g;
    logic [DW-1:0] data_g;
    logic          active;
    logic          xfer;
    logic          stall_hit;

    rr_pick3 u_pick (
        .req (fifo_vld & chan_en),
        .ptr (rr_ptr),
        .gnt (pick),
        .any (pick_any)
    );

    always_comb begin
        vld_g  = 1'b0;
        data_g = '0;
        case (grant)
            2'd0: begin vld_g = fifo_vld[0]; data_g = fifo_data_0; end
            2'd1: begin vld_g = fifo_vld[1]; data_g = fifo_data_1; end
            2'd2: begin vld_g = fifo_vld[2]; data_g = fifo_data_2; end
            default: ;
        endcase
    end

    assign active    = (state == ST_HDR) || (state == ST_BODY);
    assign out_valid = active & vld_g;
    assign xfer      = out_valid & out_ready;
    assign read_enb  = xfer ? (3'b001 << grant) : 3'b000;
    assign out_data  = out_valid ? data_g : '0;
    assign out_sop   = out_valid & (state == ST_HDR);
    assign out_eop   = out_valid & (state == ST_BODY) & (rem == 5'd1);
    assign busy      = (state != ST_IDLE);
    assign out_ch    = busy ? grant : 2'd0;

    // Only an empty granted FIFO counts as a stall; downstream backpressure never does.
    assign stall_hit = !vld_g && (stall == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= 2'd0;
            rr_ptr      <= 2'd0;
            rem         <= 5'd0;
            stall       <= '0;
            timeout_err <= 1'b0;
            hdr_err     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    stall <= '0;
                    if (pick_any) begin
                        grant <= pick;
                        state <= ST_HDR;
                    end
                end
                ST_HDR, ST_BODY: begin
                    if (!vld_g) begin
                        stall <= stall + TW'(1);
                        if (stall_hit)
                            state <= ST_ABORT;
                    end else begin
                        stall <= '0;
                    end
                    if (xfer && state == ST_HDR) begin
                        rem   <= 5'(data_g[LEN_MSB:LEN_LSB]) + 5'd1;
                        state <= ST_BODY;
                        // Mismatched channel field is flagged but forwarded as-is.
                        if (data_g[CH_MSB:CH_LSB] != grant)
                            hdr_err <= 1'b1;
                    end
                    if (xfer && state == ST_BODY) begin
                        rem <= rem - 5'd1;
                        if (rem == 5'd1) begin
                            rr_ptr <= next_ch(grant);
                            state  <= ST_IDLE;
                        end
                    end
                end
                ST_ABORT: begin
                    timeout_err <= 1'b1;
                    rr_ptr      <= next_ch(grant);
                    stall       <= '0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_drain_arbiter.sv
// Directed bench for router_drain_arbiter.
// Queue-modelled FWFT FIFOs, hand-computed expects.
module tb_router_drain_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] fifo_vld;
  logic [7:0] fifo_data_0, fifo_data_1, fifo_data_2;
  logic [2:0] chan_en;
  logic       out_ready;
  logic [2:0] read_enb;
  logic [7:0] out_data;
  logic       out_valid, out_sop, out_eop;
  logic [1:0] out_ch;
  logic       busy, timeout_err, hdr_err;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] exp3[5];

  int n_cmp = 0;
  int n_bad = 0;
  int got;

  router_drain_arbiter #(.DW(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_vld    (fifo_vld),
    .fifo_data_0 (fifo_data_0),
    .fifo_data_1 (fifo_data_1),
    .fifo_data_2 (fifo_data_2),
    .chan_en     (chan_en),
    .out_ready   (out_ready),
    .read_enb    (read_enb),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_ch      (out_ch),
    .busy        (busy),
    .timeout_err (timeout_err),
    .hdr_err     (hdr_err)
  );

  always #5 clk = ~clk;

  task automatic fail(input string t);
    n_bad++;
    $error("FAIL %s", t);
  endtask

  task automatic upd();
    fifo_vld    = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
    fifo_data_0 = (q0.size() != 0) ? q0[0] : 8'h00;
    fifo_data_1 = (q1.size() != 0) ? q1[0] : 8'h00;
    fifo_data_2 = (q2.size() != 0) ? q2[0] : 8'h00;
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    case (ch)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic cyc();
    logic [2:0] re;
    re = read_enb;
    @(posedge clk);
    #1;
    if (re[0]) void'(q0.pop_front());
    if (re[1]) void'(q1.pop_front());
    if (re[2]) void'(q2.pop_front());
    upd();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    chan_en     = 3'b111;
    out_ready   = 1'b1;
    fifo_vld    = 3'b000;
    fifo_data_0 = 8'h00;
    fifo_data_1 = 8'h00;
    fifo_data_2 = 8'h00;
    exp3 = '{8'h0C, 8'h31, 8'h32, 8'h33, 8'h3F};
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) fail("rst busy");
    n_cmp++; if (out_valid !== 1'b0) fail("rst valid");
    n_cmp++; if (read_enb !== 3'b000) fail("rst re");
    n_cmp++; if (out_sop !== 1'b0) fail("rst sop");
    n_cmp++; if (out_eop !== 1'b0) fail("rst eop");
    n_cmp++; if (out_data !== 8'h00) fail("rst data");
    n_cmp++; if (out_ch !== 2'd0) fail("rst ch");
    n_cmp++; if (timeout_err !== 1'b0) fail("rst terr");
    n_cmp++; if (hdr_err !== 1'b0) fail("rst herr");
    rst = 1'b0;
    #1;

    push(1, 8'h09); push(1, 8'h11); push(1, 8'h22); push(1, 8'h3A);
    upd();
    cyc();
    n_cmp++; if (out_data !== 8'h09) fail("t1 hdr data");
    n_cmp++; if (out_sop !== 1'b1) fail("t1 hdr sop");
    n_cmp++; if (read_enb !== 3'b010) fail("t1 hdr re");
    n_cmp++; if (out_ch !== 2'd1) fail("t1 hdr ch");
    n_cmp++; if (busy !== 1'b1) fail("t1 hdr busy");
    cyc();
    n_cmp++; if (out_data !== 8'h11) fail("t1 b1 data");
    n_cmp++; if (out_sop !== 1'b0) fail("t1 b1 sop");
    n_cmp++; if (out_eop !== 1'b0) fail("t1 b1 eop");
    n_cmp++; if (read_enb !== 3'b010) fail("t1 b1 re");
    cyc();
    n_cmp++; if (out_data !== 8'h22) fail("t1 b2 data");
    n_cmp++; if (read_enb !== 3'b010) fail("t1 b2 re");
    cyc();
    n_cmp++; if (out_data !== 8'h3A) fail("t1 par data");
    n_cmp++; if (out_eop !== 1'b1) fail("t1 par eop");
    n_cmp++; if (read_enb !== 3'b010) fail("t1 par re");
    cyc();
    n_cmp++; if (busy !== 1'b0) fail("t1 idle busy");
    n_cmp++; if (out_valid !== 1'b0) fail("t1 idle valid");
    n_cmp++; if (hdr_err !== 1'b0) fail("t1 herr");

    rst = 1'b1;
    #1;
    push(0, 8'h04); push(0, 8'hA0); push(0, 8'hF0);
    push(1, 8'h05); push(1, 8'hB0); push(1, 8'hF1);
    push(2, 8'h06); push(2, 8'hC0); push(2, 8'hF2);
    upd();
    cyc();
    rst = 1'b0;
    #1;
    cyc();
    n_cmp++; if (out_ch !== 2'd0) fail("t2 g0 ch");
    n_cmp++; if (out_data !== 8'h04) fail("t2 g0 data");
    cyc();
    n_cmp++; if (out_data !== 8'hA0) fail("t2 g0 body");
    cyc();
    n_cmp++; if (out_eop !== 1'b1) fail("t2 g0 eop");
    n_cmp++; if (out_data !== 8'hF0) fail("t2 g0 par");
    cyc();
    n_cmp++; if (busy !== 1'b0) fail("t2 gap0");
    push(0, 8'h04); push(0, 8'hA1); push(0, 8'hE0);
    push(2, 8'h06); push(2, 8'hC1); push(2, 8'hE2);
    upd();
    cyc();
    n_cmp++; if (out_ch !== 2'd1) fail("t2 g1 ch");
    n_cmp++; if (out_data !== 8'h05) fail("t2 g1 data");
    cyc();
    cyc();
    n_cmp++; if (out_data !== 8'hF1) fail("t2 g1 par");
    cyc();
    n_cmp++; if (busy !== 1'b0) fail("t2 gap1");
    cyc();
    n_cmp++; if (out_ch !== 2'd2) fail("t2 g2 ch");
    n_cmp++; if (out_data !== 8'h06) fail("t2 g2 data");
    cyc();
    cyc();
    n_cmp++; if (out_data !== 8'hF2) fail("t2 g2 par");
    cyc();
    n_cmp++; if (busy !== 1'b0) fail("t2 gap2");
    cyc();
    n_cmp++; if (out_ch !== 2'd0) fail("t2 g3 ch");
    cyc();
    cyc();
    n_cmp++; if (out_data !== 8'hE0) fail("t2 g3 par");
    cyc();
    cyc();
    n_cmp++; if (out_ch !== 2'd2) fail("t2 g4 ch");
    n_cmp++; if (q2[1] !== 8'hC1) fail("t2 g4 body");
    cyc();
    cyc();
    n_cmp++; if (out_data !== 8'hE2) fail("t2 g4 par");
    cyc();

    out_ready = 1'b0;
    push(0, 8'h0C); push(0, 8'h31); push(0, 8'h32);
    push(0, 8'h33); push(0, 8'h3F);
    upd();
    cyc();
    n_cmp++; if (out_ch !== 2'd0) fail("t3 ch");
    n_cmp++; if (out_sop !== 1'b1) fail("t3 sop");
    n_cmp++; if (read_enb !== 3'b000) fail("t3 re hold");
    repeat (40) cyc();
    n_cmp++; if (busy !== 1'b1) fail("t3 busy");
    n_cmp++; if (timeout_err !== 1'b0) fail("t3 terr");
    n_cmp++; if (out_valid !== 1'b1) fail("t3 valid");
    n_cmp++; if (out_data !== 8'h0C) fail("t3 held data");
    got = 0;
    for (int k = 0; k < 30 && got < 5; k++) begin
      out_ready = (k % 3 == 0);
      #1;
      n_cmp++;
      if (read_enb !== (out_ready ? 3'b001 : 3'b000)) fail("t3 re");
      if (out_ready) begin
        n_cmp++; if (out_data !== exp3[got]) fail("t3 data");
        n_cmp++; if (out_eop !== (got == 4)) fail("t3 eop");
        got++;
      end
      cyc();
    end
    n_cmp++; if (got != 5) fail("t3 count");
    out_ready = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) fail("t3 done");
    n_cmp++; if (timeout_err !== 1'b0) fail("t3 terr end");

    push(2, 8'h0E); push(2, 8'h51);
    upd();
    cyc();
    n_cmp++; if (out_ch !== 2'd2) fail("t4 ch");
    n_cmp++; if (out_data !== 8'h0E) fail("t4 hdr");
    cyc();
    n_cmp++; if (out_data !== 8'h51) fail("t4 body");
    cyc();
    push(0, 8'h04); push(0, 8'h71); push(0, 8'h72);
    upd();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if ({busy, timeout_err, out_valid} !== 3'b100) fail("t4 stall");
      cyc();
    end
    n_cmp++;
    if ({busy, timeout_err, out_valid} !== 3'b100) fail("t4 abort");
    cyc();
    n_cmp++; if (busy !== 1'b0) fail("t4 idle busy");
    n_cmp++; if (timeout_err !== 1'b1) fail("t4 terr");
    cyc();
    n_cmp++; if (out_ch !== 2'd0) fail("t4 next ch");
    n_cmp++; if (out_data !== 8'h04) fail("t4 next data");
    cyc();
    cyc();
    cyc();
    n_cmp++; if (timeout_err !== 1'b1) fail("t4 terr sticky");

    push(0, 8'h01); push(0, 8'h01);
    upd();
    n_cmp++; if (hdr_err !== 1'b0) fail("t5 herr pre");
    cyc();
    n_cmp++; if (out_sop !== 1'b1) fail("t5 sop");
    n_cmp++; if (out_eop !== 1'b0) fail("t5 eop0");
    n_cmp++; if (out_ch !== 2'd0) fail("t5 ch");
    cyc();
    n_cmp++; if (out_sop !== 1'b0) fail("t5 sop1");
    n_cmp++; if (out_eop !== 1'b1) fail("t5 eop");
    n_cmp++; if (out_data !== 8'h01) fail("t5 data");
    n_cmp++; if (hdr_err !== 1'b1) fail("t5 herr");
    cyc();
    n_cmp++; if (busy !== 1'b0) fail("t5 idle");

    chan_en = 3'b101;
    push(0, 8'h04); push(0, 8'hA5); push(0, 8'hA6);
    push(1, 8'h04); push(1, 8'hB5); push(1, 8'hB6);
    push(2, 8'h06); push(2, 8'hC5); push(2, 8'hC6);
    upd();
    cyc();
    n_cmp++; if (out_ch !== 2'd2) fail("t6 g ch2");
    cyc();
    cyc();
    n_cmp++; if (out_eop !== 1'b1) fail("t6 ch2 eop");
    cyc();
    n_cmp++; if (busy !== 1'b0) fail("t6 gap");
    cyc();
    n_cmp++; if (out_ch !== 2'd0) fail("t6 g ch0");
    chan_en = 3'b100;
    #1;
    cyc();
    n_cmp++; if (out_data !== 8'hA5) fail("t6 body");
    cyc();
    n_cmp++; if (out_data !== 8'hA6) fail("t6 par");
    n_cmp++; if (out_eop !== 1'b1) fail("t6 eop");
    cyc();
    n_cmp++; if (busy !== 1'b0) fail("t6 masked a");
    cyc();
    n_cmp++; if (busy !== 1'b0) fail("t6 masked b");
    chan_en = 3'b111;
    #1;
    cyc();
    n_cmp++; if (out_ch !== 2'd1) fail("t6 g ch1");
    cyc();
    n_cmp++; if (out_data !== 8'hB5) fail("t6 ch1 body");
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) fail("t6 rst valid");
    n_cmp++; if (read_enb !== 3'b000) fail("t6 rst re");
    n_cmp++; if (busy !== 1'b0) fail("t6 rst busy");
    n_cmp++; if (out_data !== 8'h00) fail("t6 rst data");
    n_cmp++; if (out_eop !== 1'b0) fail("t6 rst eop");
    n_cmp++; if (out_ch !== 2'd0) fail("t6 rst ch");
    n_cmp++; if (timeout_err !== 1'b0) fail("t6 rst terr");
    n_cmp++; if (hdr_err !== 1'b0) fail("t6 rst herr");
    push(0, 8'h04); push(0, 8'hD5); push(0, 8'hD6);
    upd();
    cyc();
    n_cmp++; if (q1.size() != 2) fail("t6 fifo kept");
    rst = 1'b0;
    #1;
    cyc();
    n_cmp++; if (out_ch !== 2'd0) fail("t6 ptr0 ch");
    n_cmp++; if (out_data !== 8'h04) fail("t6 ptr0 data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
